// File: rtl/p405s_dcu_tag_sweep_arb_if.sv
// Bundle of core, flush and tag-SRAM control signals for the DCU tag
// arbiter. The slave modport is the arbiter; the master modport is the
// side that issues core/flush requests and observes the SRAM pins.
interface p405s_dcu_tag_sweep_arb_if;
    logic        core_req;
    logic        core_rd;
    logic [7:0]  core_addr;
    logic [1:0]  core_way_we;
    logic [20:0] core_wdata;
    logic        core_valid;
    logic        core_u0;
    logic        core_ptag;
    logic        core_gnt;
    logic        core_rd_vld;
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;
    logic        sram_cen;
    logic        sram_readWrite;
    logic [7:0]  sram_addr;
    logic [5:0]  sram_bitWriteA;
    logic [5:0]  sram_bitWriteB;
    logic [20:0] sram_dataIn;
    logic        sram_p_tag;
    logic        sram_newU0Attr;
    logic        sram_newValidA;
    logic        sram_newValidB;

    modport slave (
        input  core_req, core_rd, core_addr, core_way_we, core_wdata,
               core_valid, core_u0, core_ptag, flush_req,
        output core_gnt, core_rd_vld, flush_busy, flush_done,
               sram_cen, sram_readWrite, sram_addr, sram_bitWriteA,
               sram_bitWriteB, sram_dataIn, sram_p_tag, sram_newU0Attr,
               sram_newValidA, sram_newValidB
    );

    modport master (
        output core_req, core_rd, core_addr, core_way_we, core_wdata,
               core_valid, core_u0, core_ptag, flush_req,
        input  core_gnt, core_rd_vld, flush_busy, flush_done,
               sram_cen, sram_readWrite, sram_addr, sram_bitWriteA,
               sram_bitWriteB, sram_dataIn, sram_p_tag, sram_newU0Attr,
               sram_newValidA, sram_newValidB
    );
endinterface

// File: rtl/p405s_dcu_tag_sweep_arb.sv
// DCU tag SRAM port owner: arbitrates core lookups/fills against a
// whole-array invalidate sweep, registers all SRAM controls and returns a
// read-valid strobe two cycles after a granted read.
module p405s_dcu_tag_sweep_arb #(
    parameter int NUM_SETS    = 256,
    parameter int SWEEP_DEFER = 4
) (
    input  logic                         cclk,
    input  logic                         reset_n,
    p405s_dcu_tag_sweep_arb_if.slave     bus
);
    localparam int PW = $clog2(NUM_SETS);
    localparam int DW = $clog2(SWEEP_DEFER + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_ptr;
    logic [DW-1:0] r_defer;
    logic          w_gnt;
    logic          w_slot;
    logic          w_last_set;

    logic          r_cen;
    logic          r_rw;
    logic [7:0]    r_addr;
    logic [5:0]    r_bwa;
    logic [5:0]    r_bwb;
    logic [20:0]   r_data;
    logic          r_ptag;
    logic          r_u0;
    logic          r_va;
    logic          r_vb;
    logic          r_rd_pend;
    logic          r_rd_vld;

    assign w_last_set = (r_ptr == PW'(NUM_SETS - 1));

    // State register
    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state and arbitration: core wins unless it has used up its defer budget
    always_comb begin
        w_state_next = r_state;
        w_gnt        = 1'b0;
        w_slot       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt = bus.core_req;
                if (bus.flush_req) w_state_next = ST_SWEEP;
            end
            ST_SWEEP: begin
                w_gnt  = bus.core_req && (r_defer != DW'(SWEEP_DEFER));
                w_slot = !w_gnt;
                if (w_slot && w_last_set) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_gnt        = bus.core_req;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sweep pointer and consecutive-core-grant counter
    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_defer <= '0;
        end else begin
            if (w_slot) r_ptr <= w_last_set ? '0 : r_ptr + 1'b1;
            if (r_state != ST_SWEEP || w_slot) r_defer <= '0;
            else if (w_gnt)                    r_defer <= r_defer + 1'b1;
        end
    end

    // Registered SRAM controls for the access chosen this cycle
    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cen  <= 1'b1;
            r_rw   <= 1'b1;
            r_addr <= '0;
            r_bwa  <= '0;
            r_bwb  <= '0;
            r_data <= '0;
            r_ptag <= 1'b0;
            r_u0   <= 1'b0;
            r_va   <= 1'b0;
            r_vb   <= 1'b0;
        end else if (w_gnt) begin
            r_cen  <= 1'b0;
            r_rw   <= bus.core_rd;
            r_addr <= bus.core_addr;
            if (bus.core_rd) begin
                r_bwa <= '0;
                r_bwb <= '0;
            end else begin
                r_bwa  <= {6{bus.core_way_we[0]}};
                r_bwb  <= {6{bus.core_way_we[1]}};
                r_data <= bus.core_wdata;
                r_ptag <= bus.core_ptag;
                r_u0   <= bus.core_u0;
                r_va   <= bus.core_valid & bus.core_way_we[0];
                r_vb   <= bus.core_valid & bus.core_way_we[1];
            end
        end else if (w_slot) begin
            r_cen  <= 1'b0;
            r_rw   <= 1'b0;
            r_addr <= 8'(r_ptr);
            r_bwa  <= 6'h3F;
            r_bwb  <= 6'h3F;
            r_data <= '0;
            r_ptag <= 1'b0;
            r_u0   <= 1'b0;
            r_va   <= 1'b0;
            r_vb   <= 1'b0;
        end else begin
            r_cen  <= 1'b1;
            r_rw   <= 1'b1;
            r_bwa  <= '0;
            r_bwb  <= '0;
        end
    end

    // Read latency tracking: SRAM access in N+1, data valid to the core in N+2
    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_pend <= w_gnt & bus.core_rd;
            r_rd_vld  <= r_rd_pend;
        end
    end

    assign bus.core_gnt       = w_gnt;
    assign bus.core_rd_vld    = r_rd_vld;
    assign bus.flush_busy     = (r_state != ST_IDLE);
    assign bus.flush_done     = (r_state == ST_DONE);
    assign bus.sram_cen       = r_cen;
    assign bus.sram_readWrite = r_rw;
    assign bus.sram_addr      = r_addr;
    assign bus.sram_bitWriteA = r_bwa;
    assign bus.sram_bitWriteB = r_bwb;
    assign bus.sram_dataIn    = r_data;
    assign bus.sram_p_tag     = r_ptag;
    assign bus.sram_newU0Attr = r_u0;
    assign bus.sram_newValidA = r_va;
    assign bus.sram_newValidB = r_vb;
endmodule

// File: doc/p405s_dcu_tag_sweep_arb.md
Name: p405s_dcu_tag_sweep_arb

Overview:
- Owns the single port of the DCU tag SRAM (256 sets x 2 ways: tag, valid, U0 attribute, parity).
- Arbitrates between core lookup/fill accesses and a whole-array invalidate sweep engine.
- Drives registered SRAM controls and tracks read latency back to the core.
- Used at reset-time cache init and for software flash-invalidate (dccci-all style).

Parameters:
- NUM_SETS, 256, number of congruence classes swept; sweep pointer width is log2(NUM_SETS).
- SWEEP_DEFER, 4, maximum consecutive core grants while a sweep is pending before one sweep slot is forced.

Ports:
- cclk  in  1  core clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- core_req  in  1  core access request, level.
- core_rd  in  1  1 = read lookup, 0 = write.
- core_addr  in  8  set index [0:7].
- core_way_we  in  2  write enable per way: [0] = way A, [1] = way B.
- core_wdata  in  21  tag data [0:20].
- core_valid  in  1  new valid bit, written to each enabled way.
- core_u0  in  1  new U0 attribute.
- core_ptag  in  1  tag parity.
- core_gnt  out  1  combinational; access accepted this cycle.
- core_rd_vld  out  1  SRAM read data valid for the core.
- flush_req  in  1  single-cycle pulse that starts a full invalidate sweep.
- flush_busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse on sweep completion.
- sram_cen  out  1  SRAM chip enable, active low, registered.
- sram_readWrite  out  1  1 = read, 0 = write, registered.
- sram_addr  out  8  registered.
- sram_bitWriteA  out  6  way-A byte-group write enables, registered.
- sram_bitWriteB  out  6  way-B byte-group write enables, registered.
- sram_dataIn  out  21  registered.
- sram_p_tag  out  1  registered.
- sram_newU0Attr  out  1  registered.
- sram_newValidA  out  1  registered.
- sram_newValidB  out  1  registered.

Behaviour:
- Reset values:
  - sram_cen = 1, sram_readWrite = 1.
  - sram_addr, sram_bitWriteA/B, sram_dataIn and the new* outputs = 0.
  - core_rd_vld = 0, flush_busy = 0, flush_done = 0.
  - FSM = IDLE; sweep pointer = 0; defer count = 0.
- FSM states and transitions:
  - IDLE: go to SWEEP on flush_req.
  - SWEEP: go to DONE after the write to set NUM_SETS-1 is issued.
  - DONE: one cycle, flush_done = 1, then return to IDLE.
  - flush_busy = 1 in SWEEP and DONE.
  - flush_req is ignored outside IDLE and is not queued.
- Arbitration in IDLE and DONE: core_gnt = core_req.
- Arbitration in SWEEP:
  - core_gnt = core_req && (defer_cnt != SWEEP_DEFER).
  - A sweep slot is issued whenever core_gnt = 0.
  - defer_cnt increments on each core grant and clears on each sweep slot, saturating at SWEEP_DEFER.
  - With no core traffic the sweep issues every cycle.
- Core access granted in cycle N: SRAM pins carry the access in cycle N+1 with sram_cen = 0.
  - Read: sram_readWrite = 1, bitWrite = 0.
  - Write: sram_readWrite = 0.
    - sram_bitWriteA = {6{core_way_we[0]}}, sram_bitWriteB = {6{core_way_we[1]}}.
    - sram_newValidA/B = core_valid, gated per way.
    - sram_dataIn, sram_p_tag and sram_newU0Attr come from the core inputs.
- Read return: core_rd_vld = 1 in cycle N+2 only for granted reads. Data is sampled directly from the SRAM outputs.
- Sweep slot: in the next cycle sram_cen = 0 and sram_readWrite = 0.
  - sram_addr = sweep pointer; both bitWrite vectors = 6'b111111.
  - All data, attribute, valid and parity inputs = 0.
  - The sweep pointer then increments.
- No slot in a cycle: sram_cen = 1 and sram_readWrite = 1 next cycle. Address and data hold their previous values.
- Boundary rules:
  - Pointer wraps from NUM_SETS-1 to 0 when entering DONE.
  - A sweep completes after exactly NUM_SETS sweep writes.
  - A core write to a set already swept persists.
  - A core write to a set not yet swept is later cleared; no ordering check is made.
  - flush_req in the same cycle as a core request: the core is granted that cycle and the sweep starts next cycle.
- reset_n assertion mid-sweep: abort immediately, return all outputs to reset values, no flush_done.

Test Plan:
- Reset check: hold reset_n = 0 with random inputs -> sram_cen = 1, sram_readWrite = 1, core_rd_vld = 0, flush_busy = 0. After release, idle cycles keep sram_cen = 1.
- Core read: core_req = 1, core_rd = 1, core_addr = 8'h5A in cycle 0 -> core_gnt = 1 in cycle 0; cycle 1 shows sram_cen = 0, sram_addr = 8'h5A, sram_readWrite = 1; core_rd_vld = 1 in cycle 2 only.
- Core write to way B only: core_way_we = 2'b10, core_valid = 1, core_wdata = 21'h1ABCDE -> next cycle sram_bitWriteA = 0, sram_bitWriteB = 6'h3F, sram_newValidB = 1, sram_dataIn = 21'h1ABCDE, sram_readWrite = 0.
- Idle flush: flush_req pulse, no core traffic -> 256 consecutive write cycles with addresses 0..255 and all bitWrites = 6'h3F; flush_done pulses once; flush_busy deasserts the cycle after the pulse.
- Contended flush: flush_req while core_req is held at 1 (SWEEP_DEFER = 4) -> grant pattern of 4 core grants then 1 sweep slot, repeated; sweep completes after 1280 slots; second flush_req mid-sweep is ignored.
- Reset mid-sweep: assert reset_n = 0 at sweep pointer 100 -> outputs reset, no flush_done; a new flush_req afterwards restarts at set 0.
